// File: rtl/parking_pkg.sv
// parking_pkg: shared state encoding, source-index helpers and default passcode for the parking controller
package parking_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_OPEN, S_CLOSE} state_t;
  localparam logic [63:0] RESET_CODE_DEFAULT = '1;
  function automatic logic src_is_exit(input int src, input int lanes);
    return src >= lanes;
  endfunction
  function automatic int src_lane(input int src, input int lanes);
    return src >= lanes ? src - lanes : src;
  endfunction
endpackage

// File: rtl/parking_rr_arbiter.sv
// parking_rr_arbiter: round-robin arbiter whose priority rotates past the last accepted grant
module parking_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  logic [IW-1:0] r_ptr;
  always_comb begin
    o_valid = 1'b0;
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && i_req[(int'(r_ptr) + k) % N]) begin
        o_valid = 1'b1;
        o_idx = IW'((int'(r_ptr) + k) % N);
      end
    end
    o_gnt = o_valid ? N'(1) << o_idx : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= '0;
    else if (i_accept) r_ptr <= int'(o_idx) == N - 1 ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/parking_multi_lane.sv
// parking_multi_lane: multi-lane parking gate controller with passcode entry and occupancy tracking
module parking_multi_lane
  import parking_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 6,
  parameter int CODE_W = 8,
  parameter int HOLD_CYCLES = 4,
  parameter logic [CODE_W-1:0] RESET_CODE = RESET_CODE_DEFAULT[CODE_W-1:0]
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_we,
  input  logic [CODE_W-1:0]       cfg_passcode,
  input  logic [CNT_W-1:0]        max_capacity,
  input  logic [LANES-1:0]        enter_req,
  input  logic [LANES-1:0]        exit_req,
  input  logic [LANES*CODE_W-1:0] passcode_in,
  output logic [CNT_W-1:0]        car_count,
  output logic [LANES-1:0]        entry_gate_open,
  output logic [LANES-1:0]        exit_gate_open,
  output logic [LANES-1:0]        deny,
  output logic                    lot_full,
  output logic                    lot_empty,
  output logic                    busy
);
  localparam int N = 2 * LANES;
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t r_state;
  logic [N-1:0] r_pend, r_goh, w_clr, w_gnt;
  logic [IW-1:0] r_gidx, w_idx;
  logic [CODE_W-1:0] r_code;
  logic [CNT_W-1:0] r_count;
  logic [HW-1:0] r_hold;
  logic [LANES-1:0] r_deny, w_lane_oh;
  logic w_valid, w_exit, w_ok, w_last;
  int w_lane;
  parking_rr_arbiter #(.N(N)) u_arb (
    .i_clk(clk),
    .i_rst_n(reset_n),
    .i_req(r_pend),
    .i_accept(r_state == S_IDLE && w_valid),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_valid(w_valid)
  );
  assign w_exit = src_is_exit(int'(r_gidx), LANES);
  assign w_lane = src_lane(int'(r_gidx), LANES);
  assign w_lane_oh = LANES'(1) << w_lane;
  assign w_ok = w_exit ? r_count != '0
                       : passcode_in[w_lane*CODE_W +: CODE_W] == r_code && r_count < max_capacity;
  assign w_last = r_hold == HW'(HOLD_CYCLES - 1);
  assign w_clr = r_state == S_CHECK ? r_goh : '0;
  assign entry_gate_open = r_state == S_OPEN && !w_exit ? w_lane_oh : '0;
  assign exit_gate_open = r_state == S_OPEN && w_exit ? w_lane_oh : '0;
  assign car_count = r_count;
  assign deny = r_deny;
  assign lot_full = r_count >= max_capacity;
  assign lot_empty = r_count == '0;
  assign busy = r_state != S_IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pend <= '0;
      r_goh <= '0;
      r_gidx <= '0;
      r_code <= RESET_CODE;
      r_count <= '0;
      r_hold <= '0;
      r_deny <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | {exit_req, enter_req};
      r_deny <= '0;
      if (cfg_we) r_code <= cfg_passcode;
      case (r_state)
        S_IDLE: if (w_valid) begin
          r_gidx <= w_idx;
          r_goh <= w_gnt;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_state <= w_ok ? S_OPEN : S_IDLE;
          if (w_ok) r_count <= w_exit ? r_count - 1'b1 : r_count + 1'b1;
          if (!w_ok && !w_exit) r_deny <= w_lane_oh;
        end
        S_OPEN: begin
          r_hold <= w_last ? '0 : r_hold + 1'b1;
          if (w_last) r_state <= S_CLOSE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_parking_multi_lane.sv
// tb_parking_multi_lane: table-driven transaction vectors plus a mid-OPEN reset sequence
module tb_parking_multi_lane;
  localparam int HOLD = 4;
  localparam int WIN = 26;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [7:0] cfg_passcode = '0;
  logic [5:0] max_capacity = 6'd3;
  logic [1:0] enter_req = '0;
  logic [1:0] exit_req = '0;
  logic [15:0] passcode_in = '0;
  logic [5:0] car_count;
  logic [1:0] entry_gate_open, exit_gate_open, deny;
  logic lot_full, lot_empty, busy;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  parking_multi_lane #(.LANES(2), .CNT_W(6), .CODE_W(8), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_we(cfg_we),
    .cfg_passcode(cfg_passcode),
    .max_capacity(max_capacity),
    .enter_req(enter_req),
    .exit_req(exit_req),
    .passcode_in(passcode_in),
    .car_count(car_count),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open(exit_gate_open),
    .deny(deny),
    .lot_full(lot_full),
    .lot_empty(lot_empty),
    .busy(busy)
  );
  typedef struct {
    logic [1:0] en;
    logic [1:0] ex;
    logic [7:0] pc0;
    logic [7:0] pc1;
    logic [5:0] cap;
    int cfg_at;
    logic [7:0] cfg_val;
    int f_e0;
    int f_e1;
    int f_x0;
    int f_x1;
    int dn0;
    int dn1;
    logic [5:0] cnt;
    logic full;
    logic empty;
  } vec_t;
  vec_t vecs[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_vec(input int id, input vec_t v);
    int f[4];
    int len[4];
    int dn[2];
    int ef[4];
    logic ovl;
    logic [3:0] g;
    f = '{-1, -1, -1, -1};
    len = '{0, 0, 0, 0};
    dn = '{0, 0};
    ef = '{v.f_e0, v.f_e1, v.f_x0, v.f_x1};
    ovl = 1'b0;
    @(posedge clk); #1;
    enter_req = v.en;
    exit_req = v.ex;
    passcode_in = {v.pc1, v.pc0};
    max_capacity = v.cap;
    for (int c = 1; c <= WIN; c++) begin
      @(posedge clk); #1;
      enter_req = '0;
      exit_req = '0;
      cfg_we = 1'b0;
      g = {exit_gate_open, entry_gate_open};
      if ($countones(g) > 1) ovl = 1'b1;
      for (int k = 0; k < 4; k++) if (g[k]) begin
        if (f[k] < 0) f[k] = c;
        len[k]++;
      end
      for (int k = 0; k < 2; k++) if (deny[k]) dn[k]++;
      if (c == v.cfg_at) begin
        cfg_we = 1'b1;
        cfg_passcode = v.cfg_val;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("v%0d gate%0d_first", id, k), f[k], ef[k]);
      chk($sformatf("v%0d gate%0d_len", id, k), len[k], ef[k] >= 0 ? HOLD : 0);
    end
    chk($sformatf("v%0d deny0", id), dn[0], v.dn0);
    chk($sformatf("v%0d deny1", id), dn[1], v.dn1);
    chk($sformatf("v%0d car_count", id), car_count, v.cnt);
    chk($sformatf("v%0d lot_full", id), lot_full, v.full);
    chk($sformatf("v%0d lot_empty", id), lot_empty, v.empty);
    chk($sformatf("v%0d busy", id), busy, 1'b0);
    chk($sformatf("v%0d overlap", id), ovl, 1'b0);
  endtask
  initial begin
    int gate_cycles;
    //               en     ex     pc0    pc1    cap cfg cval   fe0 fe1 fx0 fx1 d0 d1 cnt full empty
    vecs[0]  = '{2'b01, 2'b00, 8'hFF, 8'h00, 6'd3, -1, 8'h00,  3, -1, -1, -1, 0, 0, 6'd1, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 2'b00, 8'h00, 8'h12, 6'd3, -1, 8'h00, -1, -1, -1, -1, 0, 1, 6'd1, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 2'b00, 8'h00, 8'hFF, 6'd3, -1, 8'h00, -1,  3, -1, -1, 0, 0, 6'd2, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 2'b10, 8'h00, 8'h00, 6'd3, -1, 8'h00, -1, -1, -1,  3, 0, 0, 6'd1, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 2'b01, 8'hFF, 8'hFF, 6'd3, -1, 8'h00,  3, 10, 17, -1, 0, 0, 6'd2, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 2'b00, 8'hFF, 8'h00, 6'd1, -1, 8'h00, -1, -1, -1, -1, 1, 0, 6'd2, 1'b1, 1'b0};
    vecs[6]  = '{2'b10, 2'b00, 8'h00, 8'hFF, 6'd2, -1, 8'h00, -1, -1, -1, -1, 0, 1, 6'd2, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 2'b01, 8'h00, 8'h00, 6'd2, -1, 8'h00, -1, -1,  3, -1, 0, 0, 6'd1, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 2'b10, 8'h00, 8'h00, 6'd2, -1, 8'h00, -1, -1, -1,  3, 0, 0, 6'd0, 1'b0, 1'b1};
    vecs[9]  = '{2'b00, 2'b01, 8'h00, 8'h00, 6'd2, -1, 8'h00, -1, -1, -1, -1, 0, 0, 6'd0, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 2'b00, 8'hFF, 8'h00, 6'd0, -1, 8'h00, -1, -1, -1, -1, 1, 0, 6'd0, 1'b1, 1'b1};
    vecs[11] = '{2'b01, 2'b00, 8'hFF, 8'h00, 6'd5,  2, 8'hA5,  3, -1, -1, -1, 0, 0, 6'd1, 1'b0, 1'b0};
    vecs[12] = '{2'b01, 2'b00, 8'hFF, 8'h00, 6'd5, -1, 8'h00, -1, -1, -1, -1, 1, 0, 6'd1, 1'b0, 1'b0};
    vecs[13] = '{2'b01, 2'b00, 8'hA5, 8'h00, 6'd5, -1, 8'h00,  3, -1, -1, -1, 0, 0, 6'd2, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset car_count", car_count, 6'd0);
    chk("reset gates", {entry_gate_open, exit_gate_open}, 4'b0000);
    chk("reset deny", deny, 2'b00);
    chk("reset busy", busy, 1'b0);
    chk("reset lot_empty", lot_empty, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
    @(posedge clk); #1;
    enter_req = 2'b01;
    passcode_in = {8'h00, 8'hA5};
    max_capacity = 6'd5;
    @(posedge clk); #1;
    enter_req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("midopen gate", entry_gate_open, 2'b01);
    chk("midopen count", car_count, 6'd3);
    reset_n = 1'b0;
    #1;
    chk("async reset gate", {entry_gate_open, exit_gate_open}, 4'b0000);
    chk("async reset count", car_count, 6'd0);
    chk("async reset busy", busy, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    gate_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (entry_gate_open != '0 || exit_gate_open != '0) gate_cycles++;
    end
    chk("post reset no gate", gate_cycles, 0);
    run_vec(14, '{2'b10, 2'b00, 8'h00, 8'hFF, 6'd3, -1, 8'h00, -1, 3, -1, -1, 0, 0, 6'd1, 1'b0, 1'b0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
